port_endpoint: RTL and testbench

PORT_ENDPOINT -- requirements
Module: port_endpoint

---
 rtl/port_ep_pkg.sv | 18 +
 rtl/port_ep_fifo.sv | 52 +++++
 rtl/port_endpoint.sv | 187 ++++++++++++++++++
 tb/tb_port_endpoint.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_ep_pkg.sv
// Shared definitions for the switch port endpoint: TX FSM state encoding,
// switch address width and statistics counter width.
package port_ep_pkg;

  // Destination port field width on the switch side.
  localparam int unsigned ADR_W = 2;

  // Width of the optional statistics counters (PORT_EP_STATS_EN).
  localparam int unsigned STATS_W = 16;

  // TX sequencer states.
  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_DROP = 2'd2
  } tx_state_e;

endpackage

// File: rtl/port_ep_fifo.sv
// TX request FIFO for port_endpoint. Pointers carry one extra wrap bit so
// full and empty are told apart by comparing the MSBs. The head word is read
// combinationally; pushes when full and pops when empty are ignored.
module port_ep_fifo #(
  parameter int unsigned W     = 6,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     wdat_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [DEPTH:0]   count_o
);

  localparam int unsigned N = 2 ** DEPTH;

  logic [W-1:0]   mem_q [N];
  logic [DEPTH:0] wr_q;
  logic [DEPTH:0] rd_q;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (wr_q[DEPTH] != rd_q[DEPTH]) &&
                   (wr_q[DEPTH-1:0] == rd_q[DEPTH-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign count_o = wr_q - rd_q;
  assign rdat_o  = mem_q[rd_q[DEPTH-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer update; both may advance on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[DEPTH-1:0]] <= wdat_i;
  end

endmodule

// File: rtl/port_endpoint.sv
// Switch port endpoint: queues local TX requests in a FIFO and presents them
// to the switch with a valid/ack handshake, dropping a word that waits longer
// than TIMEOUT cycles. Incoming switch words land in a one-entry holding
// register with a local valid/ready handshake.
// Optional: define PORT_EP_STATS_EN to add transfer/capture/drop counters.
module port_endpoint
  import port_ep_pkg::*;
#(
  parameter int unsigned DW      = 4,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // local TX request
  input  logic             usr_valid_i,
  input  logic [DW-1:0]    usr_dat_i,
  input  logic [ADR_W-1:0] usr_adr_i,
  output logic             usr_ready_o,
  // switch port, TX direction
  output logic             validtx,
  output logic [DW-1:0]    dat_i,
  output logic [ADR_W-1:0] adr_i,
  input  logic             acktx,
  // switch port, RX direction
  input  logic             validrx,
  input  logic [DW-1:0]    dat_o,
  output logic             ackrx,
  // local RX handshake
  output logic             rx_valid_o,
  output logic [DW-1:0]    rx_dat_o,
  input  logic             rx_ready_i,
  output logic             tx_err_o
`ifdef PORT_EP_STATS_EN
  ,
  output logic [STATS_W-1:0] tx_cnt_o,
  output logic [STATS_W-1:0] rx_cnt_o,
  output logic [STATS_W-1:0] err_cnt_o
`endif
);

  localparam int unsigned FW = DW + ADR_W;
  localparam int unsigned WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  tx_state_e      state_q;
  logic [WW-1:0]  wait_q;
  logic           tx_err_q;
  logic           rx_valid_q;
  logic           rx_valid_d;
  logic [DW-1:0]  rx_dat_q;
  logic [DW-1:0]  rx_dat_d;

  logic           push;
  logic           pop;
  logic           xfer;
  logic           drop;
  logic           capture;
  logic           more_after_xfer;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FW-1:0]  fifo_head;
  logic [DEPTH:0] fifo_count;

  port_ep_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdat_i  ({usr_adr_i, usr_dat_i}),
    .pop_i   (pop),
    .rdat_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign usr_ready_o = !fifo_full;
  assign push        = usr_valid_i && !fifo_full;

  // validtx comes straight from the state register, so a reset clears it
  // asynchronously; address/data are forced to zero outside SEND.
  assign validtx        = (state_q == TX_SEND);
  assign {adr_i, dat_i} = validtx ? fifo_head : '0;
  assign xfer           = validtx && acktx;
  assign drop           = (state_q == TX_DROP);
  assign pop            = xfer || drop;
  assign tx_err_o       = tx_err_q;

  // A word pushed on the transfer edge keeps the sequencer in SEND even when
  // the popped word was the last one queued.
  assign more_after_xfer = (fifo_count > (DEPTH + 1)'(1)) || push;

  // TX sequencer: wait counter, timeout drop and error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= TX_IDLE;
      wait_q   <= '0;
      tx_err_q <= 1'b0;
    end else begin
      tx_err_q <= 1'b0;
      unique case (state_q)
        TX_IDLE: begin
          if (!fifo_empty) begin
            state_q <= TX_SEND;
            wait_q  <= '0;
          end
        end
        TX_SEND: begin
          if (acktx) begin
            wait_q <= '0;
            if (!more_after_xfer) state_q <= TX_IDLE;
          end else if (wait_q == WW'(TIMEOUT)) begin
            state_q  <= TX_DROP;
            tx_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        TX_DROP: begin
          state_q <= TX_IDLE;
          wait_q  <= '0;
        end
        default: begin
          state_q <= TX_IDLE;
          wait_q  <= '0;
        end
      endcase
    end
  end

  // RX holding register: accept only while empty, so capture and release
  // never coincide.
  assign ackrx   = !rx_valid_q;
  assign capture = validrx && !rx_valid_q;

  // Next-state of the RX holding register.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_dat_d   = rx_dat_q;
    if (capture) begin
      rx_valid_d = 1'b1;
      rx_dat_d   = dat_o;
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  // RX holding register state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_valid_q <= 1'b0;
      rx_dat_q   <= '0;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_dat_q   <= rx_dat_d;
    end
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_dat_o   = rx_dat_q;

`ifdef PORT_EP_STATS_EN
  logic [STATS_W-1:0] tx_cnt_q;
  logic [STATS_W-1:0] rx_cnt_q;
  logic [STATS_W-1:0] err_cnt_q;

  // Event counters; they wrap naturally at 2**STATS_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (xfer)    tx_cnt_q  <= tx_cnt_q + 1'b1;
      if (capture) rx_cnt_q  <= rx_cnt_q + 1'b1;
      if (drop)    err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign tx_cnt_o  = tx_cnt_q;
  assign rx_cnt_o  = rx_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_port_endpoint.sv
// Self-checking bench for port_endpoint with a queue-based reference model.
module tb_port_endpoint;

  localparam int TIMEOUT = 15;
  localparam int CAP     = 4;

  logic       clk;
  logic       rst_i;
  logic       usr_valid_i;
  logic [3:0] usr_dat_i;
  logic [1:0] usr_adr_i;
  logic       usr_ready_o;
  logic       validtx;
  logic [3:0] dat_i;
  logic [1:0] adr_i;
  logic       acktx;
  logic       validrx;
  logic [3:0] dat_o;
  logic       ackrx;
  logic       rx_valid_o;
  logic [3:0] rx_dat_o;
  logic       rx_ready_i;
  logic       tx_err_o;
`ifdef PORT_EP_STATS_EN
  logic [15:0] tx_cnt_o;
  logic [15:0] rx_cnt_o;
  logic [15:0] err_cnt_o;
`endif

  port_endpoint #(.DW(4), .DEPTH(2), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .usr_valid_i (usr_valid_i),
    .usr_dat_i   (usr_dat_i),
    .usr_adr_i   (usr_adr_i),
    .usr_ready_o (usr_ready_o),
    .validtx     (validtx),
    .dat_i       (dat_i),
    .adr_i       (adr_i),
    .acktx       (acktx),
    .validrx     (validrx),
    .dat_o       (dat_o),
    .ackrx       (ackrx),
    .rx_valid_o  (rx_valid_o),
    .rx_dat_o    (rx_dat_o),
    .rx_ready_i  (rx_ready_i),
    .tx_err_o    (tx_err_o)
`ifdef PORT_EP_STATS_EN
    ,
    .tx_cnt_o    (tx_cnt_o),
    .rx_cnt_o    (rx_cnt_o),
    .err_cnt_o   (err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: queued words as adr*16+dat, plus "sending"/"dropping"
  // flags and the cycles the head word has waited.
  int q[$];
  bit m_send;
  bit m_drop;
  int m_wait;
  bit m_rxv;
  int m_rxd;
  int m_tx;
  int m_rx;
  int m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_send = 0; m_drop = 0; m_wait = 0;
    m_rxv = 0; m_rxd = 0;
    m_tx = 0; m_rx = 0; m_err = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit push;
    push = usr_valid_i && (q.size() < CAP);
    if (m_drop) begin
      void'(q.pop_front());
      m_drop = 0;
      m_err++;
    end else if (m_send) begin
      if (acktx) begin
        void'(q.pop_front());
        m_tx++;
        m_wait = 0;
        if (q.size() == 0 && !push) m_send = 0;
      end else if (m_wait == TIMEOUT) begin
        m_send = 0;
        m_drop = 1;
      end else begin
        m_wait++;
      end
    end else if (q.size() != 0) begin
      m_send = 1;
      m_wait = 0;
    end
    if (push) q.push_back(int'(usr_adr_i) * 16 + int'(usr_dat_i));
    if (!m_rxv && validrx) begin
      m_rxv = 1;
      m_rxd = int'(dat_o);
      m_rx++;
    end else if (m_rxv && rx_ready_i) begin
      m_rxv = 0;
    end
  endtask

  task automatic check_outputs();
    int hd;
    hd = m_send ? q[0] : 0;
    chk("validtx",     32'(validtx),     32'(m_send));
    chk("dat_i",       32'(dat_i),       32'(hd % 16));
    chk("adr_i",       32'(adr_i),       32'(hd / 16));
    chk("usr_ready_o", 32'(usr_ready_o), 32'(q.size() < CAP));
    chk("tx_err_o",    32'(tx_err_o),    32'(m_drop));
    chk("ackrx",       32'(ackrx),       32'(!m_rxv));
    chk("rx_valid_o",  32'(rx_valid_o),  32'(m_rxv));
    chk("rx_dat_o",    32'(rx_dat_o),    32'(m_rxd));
`ifdef PORT_EP_STATS_EN
    chk("tx_cnt_o",  32'(tx_cnt_o),  32'(m_tx % 65536));
    chk("rx_cnt_o",  32'(rx_cnt_o),  32'(m_rx % 65536));
    chk("err_cnt_o", 32'(err_cnt_o), 32'(m_err % 65536));
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    usr_valid_i = 0; usr_dat_i = '0; usr_adr_i = '0;
    acktx = 0; validrx = 0; dat_o = '0; rx_ready_i = 0;
  endtask

  int cnt_v;
  int cnt_e;
  int guard;

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_i = 1'b0;
    cycle();

    // Four words, acktx held high: back-to-back transfers in order.
    acktx = 1;
    for (int i = 0; i < 4; i++) begin
      usr_valid_i = 1;
      usr_adr_i   = 2'((i + 1) % 4);
      usr_dat_i   = 4'(10 + i);
      cycle();
    end
    usr_valid_i = 0;
    repeat (6) cycle();

    // One word never acknowledged: TIMEOUT+1 cycles of validtx, then one drop.
    acktx = 0;
    usr_valid_i = 1; usr_adr_i = 2'd2; usr_dat_i = 4'h7;
    cycle();
    usr_valid_i = 0;
    cnt_v = 0; cnt_e = 0;
    repeat (22) begin
      cycle();
      cnt_v += int'(validtx);
      cnt_e += int'(tx_err_o);
    end
    chk("timeout_validtx_cycles", 32'(cnt_v), 32'(TIMEOUT + 1));
    chk("timeout_err_pulses",     32'(cnt_e), 32'd1);
    chk("timeout_fifo_empty",     32'(usr_ready_o), 32'd1);

    // Two words with acktx 1,0,0,1.
    usr_valid_i = 1; usr_adr_i = 2'd1; usr_dat_i = 4'h3; cycle();
    usr_adr_i = 2'd3; usr_dat_i = 4'h9; cycle();
    usr_valid_i = 0;
    cnt_e = 0;
    acktx = 1; cycle(); cnt_e += int'(tx_err_o);
    acktx = 0; cycle(); cnt_e += int'(tx_err_o);
    cycle();            cnt_e += int'(tx_err_o);
    acktx = 1; cycle(); cnt_e += int'(tx_err_o);
    acktx = 0;
    repeat (3) cycle();
    chk("ack_pattern_no_err", 32'(cnt_e), 32'd0);

    // RX: word held while the local side is not ready, then released.
    validrx = 1; dat_o = 4'h5; rx_ready_i = 0;
    repeat (3) cycle();
    chk("rx_hold_dat", 32'(rx_dat_o), 32'h5);
    rx_ready_i = 1; dat_o = 4'h6;
    cycle();
    rx_ready_i = 0;
    cycle();
    chk("rx_next_dat", 32'(rx_dat_o), 32'h6);
    validrx = 0;
    repeat (2) cycle();

    // Randomized traffic on both directions.
    for (int i = 0; i < 400; i++) begin
      usr_valid_i = 1'($urandom_range(0, 1));
      usr_adr_i   = 2'($urandom_range(0, 3));
      usr_dat_i   = 4'($urandom_range(0, 15));
      acktx       = (i >= 300) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
      validrx     = 1'($urandom_range(0, 1));
      dat_o       = 4'($urandom_range(0, 15));
      rx_ready_i  = 1'($urandom_range(0, 1));
      cycle();
    end
    idle_inputs();
    repeat (25) cycle();

    // Reset in the middle of SEND with three words queued.
    acktx = 0;
    for (int i = 0; i < 3; i++) begin
      usr_valid_i = 1; usr_adr_i = 2'(i); usr_dat_i = 4'(i + 1);
      cycle();
    end
    usr_valid_i = 0;
    chk("pre_reset_in_send", 32'(validtx), 32'd1);
    rst_i = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst_i = 1'b0;
    repeat (3) cycle();

`ifdef PORT_EP_STATS_EN
    // Counter wrap: 65537 transfers from reset leave tx_cnt_o at 1.
    acktx = 1;
    usr_valid_i = 1;
    guard = 0;
    while (m_tx < 65537 && guard < 70000) begin
      usr_adr_i = 2'($urandom_range(0, 3));
      usr_dat_i = 4'($urandom_range(0, 15));
      if (m_tx >= 65535) usr_valid_i = 0;
      cycle();
      guard++;
    end
    chk("tx_cnt_wrap", 32'(tx_cnt_o), 32'd1);
    idle_inputs();
    repeat (3) cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
